// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter for the writeback stage. Each cycle it picks one of
//   eight functional-unit result requests and drives the select of the external
//   8:1 result/tag muxes. The selected result is registered onto the CDB and held
//   there for the reservation stations, the ROB and the register file.
//
//   Build option: CDB_FIXED_PRIO_EN
//     undefined (default): round-robin. The search starts at rr_ptr and wraps
//                          from 7 to 0. After a transfer, rr_ptr moves to the
//                          entry after the winner.
//     defined:             fixed priority with index 0 highest. There is no
//                          rr_ptr, so an FU can starve. mux_sel is 0 when idle.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   flush      pipeline flush; kills the CDB broadcast and blocks grants
//   fu_valid   per-FU result pending
//   fu_ready   per-FU grant (one-hot or zero)
//   mux_sel    select for the external result/tag muxes
//   mux_data   result mux output
//   mux_tag    tag mux output
//   cdb_valid  CDB holds a valid broadcast
//   cdb_data   registered broadcast result
//   cdb_tag    registered broadcast tag
//   cdb_ready  all CDB consumers accept this cycle
module cdb_arbiter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic [7:0]       fu_valid,
   output logic [7:0]       fu_ready,
   output logic [2:0]       mux_sel,
   input  logic [WIDTH-1:0] mux_data,
   input  logic [TAG_W-1:0] mux_tag,
   output logic             cdb_valid,
   output logic [WIDTH-1:0] cdb_data,
   output logic [TAG_W-1:0] cdb_tag,
   input  logic             cdb_ready
);

   logic       load_en;
   logic       any_valid;
   logic       transfer;
   logic [2:0] winner;

   // Grants are held off while reset is asserted. The result of a transfer
   // attempted under reset would be dropped anyway.
   assign load_en   = resetn & ~flush & (~cdb_valid | cdb_ready);
   assign any_valid = |fu_valid;
   assign transfer  = load_en & any_valid;
   assign fu_ready  = transfer ? (8'b1 << winner) : 8'b0;

`ifdef CDB_FIXED_PRIO_EN

   // The scan runs downward, so the lowest set index is written last and wins.
   always_comb begin
      winner = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (fu_valid[k]) winner = k[2:0];
      end
   end

   assign mux_sel = winner;

`else

   logic [2:0] rr_ptr;
   logic [2:0] idx;

   // The scan runs downward over the offset from rr_ptr, so the nearest
   // requester at or after rr_ptr is written last and wins.
   always_comb begin
      winner = rr_ptr;
      idx    = rr_ptr;
      for (int k = 7; k >= 0; k--) begin
         idx = rr_ptr + k[2:0];
         if (fu_valid[idx]) winner = idx;
      end
   end

   assign mux_sel = winner;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr <= 3'd0;
      end else if (transfer) begin
         rr_ptr <= winner + 3'd1;
      end
   end

`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cdb_valid <= 1'b0;
         cdb_data  <= '0;
         cdb_tag   <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else if (transfer) begin
         cdb_valid <= 1'b1;
         cdb_data  <= mux_data;
         cdb_tag   <= mux_tag;
      end else if (cdb_valid && cdb_ready) begin
         cdb_valid <= 1'b0;
      end
   end

endmodule
